// File: rtl/rob_multi.sv
// rob_multi: multi-commit reorder buffer. Allocates in program order, captures
// results from several CDB lanes, retires up to COMMIT_WIDTH entries per cycle,
// handshakes stores with the LSQ and squashes younger work on a taken branch.

package rob_multi_pkg;
  localparam int unsigned CDB_TAG_W = 8;

  typedef enum logic [1:0] {
    op_alu,
    op_load,
    op_store,
    op_br
  } i_decode_opcode_t;

  typedef struct packed {
    logic [CDB_TAG_W-1:0] tag;
    logic [31:0]          value;
    logic [31:0]          target_pc;
  } cdb_t;

  typedef struct packed {
    logic             valid;
    logic             ready;
    i_decode_opcode_t op;
    logic [31:0]      value;
    logic [31:0]      target_pc;
  } rob_values_t;
endpackage

module rob_multi
  import rob_multi_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CDB_PORTS    = 2,
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned TAG_W        = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          alloc_valid,
  input  i_decode_opcode_t              alloc_op,
  output logic                          alloc_ready,
  output logic [TAG_W-1:0]              alloc_tag,
  input  cdb_t [CDB_PORTS-1:0]          cdb,
  output logic [COMMIT_WIDTH-1:0]       commit_valid,
  output rob_values_t [COMMIT_WIDTH-1:0] commit_data,
  output logic                          head_is_store,
  output logic [TAG_W-1:0]              head_tag,
  input  logic                          store_done,
  output logic                          pcmux_sel,
  output logic [31:0]                   target_pc,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  rob_values_t                     ent_q [DEPTH];
  rob_values_t                     ent_d [DEPTH];
  logic [IDX_W-1:0]                head_q, head_d;
  logic [IDX_W-1:0]                tail_q, tail_d;
  logic [CNT_W-1:0]                count_q, count_d;
  logic [COMMIT_WIDTH-1:0]         cv_q, cv_d;
  rob_values_t [COMMIT_WIDTH-1:0]  cd_q, cd_d;
  logic                            pcmux_q, pcmux_d;
  logic [31:0]                     tpc_q, tpc_d;

  logic [IDX_W-1:0]                idx;
  rob_values_t                     ent;
  logic                            take;
  logic                            scan_on;
  logic                            squash;
  logic                            alloc_fire;
  int unsigned                     retire_n;

  // Circular index arithmetic; DEPTH need not be a power of two.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned      n);
    return IDX_W'((32'(base) + n) % DEPTH);
  endfunction

  // Status outputs derived from registered state only.
  always_comb begin
    alloc_ready   = (32'(count_q) < DEPTH);
    alloc_tag     = TAG_W'(32'(tail_q) + 1);
    empty         = (count_q == '0);
    head_tag      = empty ? '0 : TAG_W'(32'(head_q) + 1);
    head_is_store = ent_q[head_q].valid && ent_q[head_q].ready &&
                    (ent_q[head_q].op == op_store);
  end

  // Next-state: retirement scan, CDB capture, allocation, squash and flush.
  always_comb begin
    ent_d    = ent_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    cv_d     = '0;
    cd_d     = '0;
    pcmux_d  = 1'b0;
    tpc_d    = '0;
    retire_n = 0;
    scan_on  = 1'b1;
    squash   = 1'b0;
    idx      = '0;
    ent      = '0;
    take     = 1'b0;

    // Scan reads registered readiness, so a capture needs one edge before it retires.
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      idx  = wrap_add(head_q, k);
      ent  = ent_q[idx];
      take = 1'b0;
      if (scan_on && ent.valid && ent.ready) begin
        unique case (ent.op)
          op_store: take = (k == 0) && store_done;
          op_br: begin
            take = 1'b1;
            if (ent.value != '0) begin
              squash  = 1'b1;
              pcmux_d = 1'b1;
              tpc_d   = ent.target_pc;
            end
          end
          default: begin
            take     = 1'b1;
            cv_d[k]  = 1'b1;
            cd_d[k]  = ent;
          end
        endcase
      end
      if (take) begin
        ent_d[idx] = '0;
        retire_n++;
      end
      if (!take || squash) scan_on = 1'b0;
    end

    for (int unsigned l = 0; l < CDB_PORTS; l++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (cdb[l].tag == CDB_TAG_W'(i + 1) && ent_q[i].valid && !ent_q[i].ready) begin
          ent_d[i].value     = cdb[l].value;
          ent_d[i].target_pc = cdb[l].target_pc;
          ent_d[i].ready     = 1'b1;
        end
      end
    end

    alloc_fire = alloc_valid && alloc_ready && !squash;
    if (alloc_fire) begin
      ent_d[tail_q] = '{valid: 1'b1, ready: 1'b0, op: alloc_op, value: '0, target_pc: '0};
      tail_d        = wrap_add(tail_q, 1);
    end

    head_d  = wrap_add(head_q, retire_n);
    count_d = CNT_W'(32'(count_q) + 32'(alloc_fire) - retire_n);

    // Taken branch: everything younger is wrong-path; restart empty at the new head.
    if (squash) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_d[i] = '0;
      tail_d  = head_d;
      count_d = '0;
    end

    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      cv_d    = '0;
      cd_d    = '0;
      pcmux_d = 1'b0;
      tpc_d   = '0;
    end
  end

  // State and registered commit/redirect outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cv_q    <= '0;
      cd_q    <= '0;
      pcmux_q <= 1'b0;
      tpc_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cv_q    <= cv_d;
      cd_q    <= cd_d;
      pcmux_q <= pcmux_d;
      tpc_q   <= tpc_d;
    end
  end

  assign commit_valid = cv_q;
  assign commit_data  = cd_q;
  assign pcmux_sel    = pcmux_q;
  assign target_pc    = tpc_q;
  assign count        = count_q;

endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi: directed scenarios plus randomized traffic against a
// queue-based program-order model of the reorder buffer.
module tb_rob_multi;
  import rob_multi_pkg::*;

  localparam int unsigned D  = 8;
  localparam int unsigned NP = 2;
  localparam int unsigned CW = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  flush = 1'b0;
  logic                  alloc_valid = 1'b0;
  i_decode_opcode_t      alloc_op = op_alu;
  logic                  alloc_ready;
  logic [3:0]            alloc_tag;
  cdb_t [NP-1:0]         cdb = '0;
  logic [CW-1:0]         commit_valid;
  rob_values_t [CW-1:0]  commit_data;
  logic                  head_is_store;
  logic [3:0]            head_tag;
  logic                  store_done = 1'b0;
  logic                  pcmux_sel;
  logic [31:0]           target_pc;
  logic [3:0]            count;
  logic                  empty;

  rob_multi #(.DEPTH(D), .CDB_PORTS(NP), .COMMIT_WIDTH(CW), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_op(alloc_op), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag), .cdb(cdb), .commit_valid(commit_valid),
    .commit_data(commit_data), .head_is_store(head_is_store), .head_tag(head_tag),
    .store_done(store_done), .pcmux_sel(pcmux_sel), .target_pc(target_pc),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Program-order model: queue front is the oldest live instruction.
  typedef struct {
    int               tag;
    i_decode_opcode_t op;
    logic [31:0]      val;
    logic [31:0]      tpc;
    bit               rdy;
  } ment_t;

  ment_t                mq[$];
  int                   mtl = 0;
  logic [CW-1:0]        e_cv = '0;
  rob_values_t [CW-1:0] e_cd = '0;
  logic                 e_pc = 1'b0;
  logic [31:0]          e_tpc = '0;

  function automatic int find_tag(input int tag);
    for (int j = 0; j < mq.size(); j++) if (mq[j].tag == tag) return j;
    return -1;
  endfunction

  task automatic cycle(input bit av, input i_decode_opcode_t op,
                       input int t0, input logic [31:0] v0, input logic [31:0] p0,
                       input int t1, input logic [31:0] v1, input logic [31:0] p1,
                       input bit sd, input bit fl);
    int n;
    bit sq;
    bit can_alloc;
    int hd0;
    int tg[2];
    logic [31:0] vv[2];
    logic [31:0] pp[2];
    alloc_valid = av; alloc_op = op; store_done = sd; flush = fl;
    cdb[0] = '{tag: 8'(t0), value: v0, target_pc: p0};
    cdb[1] = '{tag: 8'(t1), value: v1, target_pc: p1};
    tg[0] = t0; vv[0] = v0; pp[0] = p0;
    tg[1] = t1; vv[1] = v1; pp[1] = p1;
    e_cv = '0; e_cd = '0; e_pc = 1'b0; e_tpc = '0;
    n = 0; sq = 0;
    if (fl) begin
      mq.delete();
      mtl = 0;
    end else begin
      can_alloc = (mq.size() < D);
      hd0 = (mq.size() > 0) ? mq[0].tag - 1 : 0;
      for (int k = 0; k < CW && k < mq.size(); k++) begin
        if (!mq[k].rdy) break;
        if (mq[k].op == op_store) begin
          if (k == 0 && sd) n++;
          else break;
        end else if (mq[k].op == op_br) begin
          n++;
          if (mq[k].val != 0) begin
            sq = 1; e_pc = 1'b1; e_tpc = mq[k].tpc;
            break;
          end
        end else begin
          n++;
          e_cv[k] = 1'b1;
          e_cd[k] = '{valid: 1'b1, ready: 1'b1, op: mq[k].op, value: mq[k].val, target_pc: mq[k].tpc};
        end
      end
      for (int l = 0; l < 2; l++) begin
        int j;
        j = find_tag(tg[l]);
        if (tg[l] != 0 && j >= 0 && !mq[j].rdy) begin
          mq[j].val = vv[l]; mq[j].tpc = pp[l]; mq[j].rdy = 1;
        end
      end
      repeat (n) void'(mq.pop_front());
      if (sq) begin
        mq.delete();
        mtl = (hd0 + n) % D;
      end else if (av && can_alloc) begin
        mq.push_back('{tag: mtl + 1, op: op, val: 0, tpc: 0, rdy: 0});
        mtl = (mtl + 1) % D;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, op_alu, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc1(input i_decode_opcode_t op);
    cycle(1, op, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cap(input int t0, input logic [31:0] v0, input logic [31:0] p0,
                     input int t1, input logic [31:0] v1, input logic [31:0] p1);
    cycle(0, op_alu, t0, v0, p0, t1, v1, p1, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; alloc_valid = 0; flush = 0; store_done = 0; cdb = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    mq.delete(); mtl = 0; e_cv = '0; e_cd = '0; e_pc = 0; e_tpc = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (commit_valid !== 2'b00) $display("FAIL reset_cv got %b want 00", commit_valid); else n_pass++;
    n_chk++; if (commit_data !== '0) $display("FAIL reset_cd got %h want 0", commit_data); else n_pass++;
    n_chk++; if (pcmux_sel !== 1'b0 || target_pc !== 32'd0) $display("FAIL reset_redirect got %b/%h want 0/0", pcmux_sel, target_pc); else n_pass++;
    n_chk++; if (count !== 4'd0 || empty !== 1'b1) $display("FAIL reset_count got %0d/%b want 0/1", count, empty); else n_pass++;
    n_chk++; if (alloc_ready !== 1'b1 || alloc_tag !== 4'd1) $display("FAIL reset_alloc got %b/%0d want 1/1", alloc_ready, alloc_tag); else n_pass++;
    n_chk++; if (head_tag !== 4'd0 || head_is_store !== 1'b0) $display("FAIL reset_head got %0d/%b want 0/0", head_tag, head_is_store); else n_pass++;
  endtask

  task automatic test_basic_commit();
    do_reset();
    repeat (3) alloc1(op_alu);
    n_chk++; if (count !== 4'd3 || head_tag !== 4'd1) $display("FAIL basic_alloc got cnt %0d head %0d want 3/1", count, head_tag); else n_pass++;
    cap(3, 30, 0, 0, 0, 0);
    cap(1, 10, 0, 2, 20, 0);
    idle();
    n_chk++; if (commit_valid !== 2'b11 || commit_data[0].value !== 32'd10 || commit_data[1].value !== 32'd20)
      $display("FAIL basic_pair got %b %0d %0d want 11 10 20", commit_valid, commit_data[0].value, commit_data[1].value); else n_pass++;
    idle();
    n_chk++; if (commit_valid !== 2'b01 || commit_data[0].value !== 32'd30)
      $display("FAIL basic_single got %b %0d want 01 30", commit_valid, commit_data[0].value); else n_pass++;
    n_chk++; if (count !== 4'd0 || empty !== 1'b1) $display("FAIL basic_drain got %0d/%b want 0/1", count, empty); else n_pass++;
  endtask

  task automatic test_full_wrap();
    int got[$];
    int exp_v[8] = '{103, 104, 105, 106, 107, 108, 201, 202};
    do_reset();
    repeat (8) alloc1(op_alu);
    n_chk++; if (alloc_ready !== 1'b0 || count !== 4'd8) $display("FAIL full_state got %b/%0d want 0/8", alloc_ready, count); else n_pass++;
    alloc1(op_alu);
    n_chk++; if (count !== 4'd8 || alloc_tag !== 4'd1) $display("FAIL full_drop got %0d/%0d want 8/1", count, alloc_tag); else n_pass++;
    cap(1, 101, 0, 2, 102, 0);
    idle();
    n_chk++; if (commit_valid !== 2'b11 || commit_data[0].value !== 32'd101 || commit_data[1].value !== 32'd102)
      $display("FAIL full_retire got %b %0d %0d want 11 101 102", commit_valid, commit_data[0].value, commit_data[1].value); else n_pass++;
    n_chk++; if (count !== 4'd6 || alloc_tag !== 4'd1) $display("FAIL wrap_tag1 got %0d/%0d want 6/1", count, alloc_tag); else n_pass++;
    alloc1(op_alu);
    n_chk++; if (alloc_tag !== 4'd2) $display("FAIL wrap_tag2 got %0d want 2", alloc_tag); else n_pass++;
    alloc1(op_alu);
    n_chk++; if (count !== 4'd8) $display("FAIL wrap_refill got %0d want 8", count); else n_pass++;
    for (int p = 0; p < 5; p++) begin
      if (p < 3) cap(3 + 2 * p, 103 + 2 * p, 0, 4 + 2 * p, 104 + 2 * p, 0);
      else if (p == 3) cap(1, 201, 0, 2, 202, 0);
      else idle();
      for (int k = 0; k < CW; k++) if (commit_valid[k]) got.push_back(int'(commit_data[k].value));
    end
    for (int i = 0; i < 10 && !empty; i++) begin
      idle();
      for (int k = 0; k < CW; k++) if (commit_valid[k]) got.push_back(int'(commit_data[k].value));
    end
    n_chk++; if (got.size() != 8) $display("FAIL wrap_n got %0d want 8", got.size()); else n_pass++;
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      n_chk++; if (got[i] != exp_v[i]) $display("FAIL wrap_order[%0d] got %0d want %0d", i, got[i], exp_v[i]); else n_pass++;
    end
  endtask

  task automatic test_store();
    do_reset();
    alloc1(op_store);
    alloc1(op_alu);
    cap(1, 0, 0, 2, 55, 0);
    repeat (3) begin
      idle();
      n_chk++; if (head_is_store !== 1'b1 || commit_valid !== 2'b00 || count !== 4'd2)
        $display("FAIL store_wait got his %b cv %b cnt %0d want 1 00 2", head_is_store, commit_valid, count); else n_pass++;
    end
    cycle(0, op_alu, 0, 0, 0, 0, 0, 0, 1, 0);
    n_chk++; if (commit_valid !== 2'b10 || commit_data[1].value !== 32'd55 || count !== 4'd0)
      $display("FAIL store_retire got cv %b val %0d cnt %0d want 10 55 0", commit_valid, commit_data[1].value, count); else n_pass++;
  endtask

  task automatic test_taken_branch();
    do_reset();
    alloc1(op_alu);
    alloc1(op_br);
    alloc1(op_alu);
    cap(1, 7, 0, 2, 1, 32'h80);
    cycle(1, op_alu, 3, 9, 0, 0, 0, 0, 0, 0);
    n_chk++; if (commit_valid !== 2'b01 || commit_data[0].value !== 32'd7)
      $display("FAIL br_commit got %b %0d want 01 7", commit_valid, commit_data[0].value); else n_pass++;
    n_chk++; if (pcmux_sel !== 1'b1 || target_pc !== 32'h80) $display("FAIL br_redirect got %b %h want 1 80", pcmux_sel, target_pc); else n_pass++;
    n_chk++; if (count !== 4'd0 || empty !== 1'b1 || alloc_tag !== 4'd3)
      $display("FAIL br_squash got cnt %0d empty %b tag %0d want 0 1 3", count, empty, alloc_tag); else n_pass++;
    idle();
    n_chk++; if (pcmux_sel !== 1'b0 || target_pc !== 32'd0 || commit_valid !== 2'b00)
      $display("FAIL br_pulse got %b %h %b want 0 0 00", pcmux_sel, target_pc, commit_valid); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    repeat (5) alloc1(op_alu);
    cycle(1, op_alu, 1, 44, 0, 0, 0, 0, 0, 1);
    n_chk++; if (count !== 4'd0 || empty !== 1'b1 || alloc_tag !== 4'd1 || head_tag !== 4'd0)
      $display("FAIL flush_state got cnt %0d empty %b tag %0d head %0d want 0 1 1 0", count, empty, alloc_tag, head_tag); else n_pass++;
    idle();
    n_chk++; if (commit_valid !== 2'b00) $display("FAIL flush_nocommit got %b want 00", commit_valid); else n_pass++;
  endtask

  task automatic test_cdb_corners();
    do_reset();
    alloc1(op_alu);
    alloc1(op_alu);
    cap(2, 22, 0, 0, 0, 0);
    cap(0, 99, 0, 5, 98, 0);
    n_chk++; if (count !== 4'd2 || commit_valid !== 2'b00) $display("FAIL cdb_ignore got %0d %b want 2 00", count, commit_valid); else n_pass++;
    cap(2, 97, 0, 0, 0, 0);
    cap(1, 11, 0, 0, 0, 0);
    idle();
    n_chk++; if (commit_valid !== 2'b11 || commit_data[0].value !== 32'd11 || commit_data[1].value !== 32'd22)
      $display("FAIL cdb_keep got %b %0d %0d want 11 11 22", commit_valid, commit_data[0].value, commit_data[1].value); else n_pass++;
  endtask

  function automatic logic [31:0] val_for(input int tag);
    int j;
    j = find_tag(tag);
    if (j >= 0 && mq[j].op == op_br) return 32'($urandom_range(0, 3) == 0);
    return $urandom;
  endfunction

  task automatic test_random();
    int t[2];
    logic [31:0] v[2];
    bit av, sd, fl;
    i_decode_opcode_t op;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int cand[$];
      for (int j = 0; j < mq.size(); j++) if (!mq[j].rdy) cand.push_back(mq[j].tag);
      for (int l = 0; l < 2; l++) begin
        if (cand.size() > 0 && $urandom_range(0, 9) < 6) t[l] = cand[$urandom_range(0, cand.size() - 1)];
        else t[l] = $urandom_range(0, D);
        v[l] = val_for(t[l]);
      end
      if (t[1] == t[0]) t[1] = 0;
      av = ($urandom_range(0, 3) != 0);
      op = i_decode_opcode_t'($urandom_range(0, 3));
      sd = $urandom_range(0, 1);
      fl = ($urandom_range(0, 63) == 0);
      cycle(av, op, t[0], v[0], $urandom, t[1], v[1], $urandom, sd, fl);
      n_chk++;
      if (count !== 4'(mq.size()) || empty !== (mq.size() == 0) || alloc_ready !== (mq.size() < D) ||
          alloc_tag !== 4'(mtl + 1) || head_tag !== 4'((mq.size() > 0) ? mq[0].tag : 0) ||
          head_is_store !== (mq.size() > 0 && mq[0].rdy && mq[0].op == op_store))
        $display("FAIL rnd_state c%0d got cnt %0d tag %0d head %0d his %b want cnt %0d tag %0d", c, count, alloc_tag, head_tag, head_is_store, mq.size(), mtl + 1);
      else n_pass++;
      n_chk++;
      if (commit_valid !== e_cv) $display("FAIL rnd_cv c%0d got %b want %b", c, commit_valid, e_cv); else n_pass++;
      for (int k = 0; k < CW; k++) if (e_cv[k]) begin
        n_chk++;
        if (commit_data[k] !== e_cd[k]) $display("FAIL rnd_cd c%0d lane %0d got %h want %h", c, k, commit_data[k], e_cd[k]); else n_pass++;
      end
      n_chk++;
      if (pcmux_sel !== e_pc || target_pc !== e_tpc) $display("FAIL rnd_redirect c%0d got %b %h want %b %h", c, pcmux_sel, target_pc, e_pc, e_tpc); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_full_wrap();
    test_store();
    test_taken_branch();
    test_flush();
    test_cdb_corners();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rob_multi.md
# rob_multi

Parametrised multi-commit reorder buffer: successor to the single-commit ROB in the execute stage. It allocates entries in program order from the decoder, captures results from `CDB_PORTS` common-data-bus lanes, and retires up to `COMMIT_WIDTH` completed entries per cycle to the regfile and reservation stations. Stores retire through a handshake with the load/store queue. A taken branch at retirement issues a PC redirect and squashes every younger entry internally.

## Interface
- `DEPTH`, 8: number of entries. Must be ≥2.
- `CDB_PORTS`, 2: number of CDB writeback lanes.
- `COMMIT_WIDTH`, 2: maximum retirements per cycle. Range 1..`DEPTH`.
- `TAG_W`, `$clog2(DEPTH+1)`: tag width. Tag = index+1; tag 0 means "no tag".
- `clk` in 1: clock. One clock domain; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: external squash of all entries.
- `alloc_valid` in 1: decoder presents an instruction.
- `alloc_op` in `i_decode_opcode_t`: decoded instruction.
- `alloc_ready` out 1: buffer can accept an entry this cycle.
- `alloc_tag` out `TAG_W`: tag the current allocation receives (tail index+1).
- `cdb` in `cdb_t`: `CDB_PORTS` lanes, each carrying tag, value and target_pc.
- `commit_valid` out `COMMIT_WIDTH`: per-lane regfile commit strobe. Registered.
- `commit_data` out `COMMIT_WIDTH` x `rob_values_t`: committed entries. Registered.
- `head_is_store` out 1: head entry is `op_store`, valid and ready.
- `head_tag` out `TAG_W`: tag of the head entry, or 0 when empty.
- `store_done` in 1: the load/store queue finished the head store.
- `pcmux_sel` out 1: redirect pulse. Registered.
- `target_pc` out 32: redirect target. Valid when `pcmux_sel`=1, otherwise 0.
- `count` out `$clog2(DEPTH+1)`: occupied entries.
- `empty` out 1: `count`==0.

## Operation
- Circular array. `head` and `tail` are indices 0..`DEPTH`-1 that wrap from `DEPTH`-1 to 0. Full and empty are distinguished by `count`, not by comparing pointers.
- `alloc_ready` = (`count` < `DEPTH`).
- Allocation occurs when `alloc_valid && alloc_ready`:
  - entry[tail] gets the op, valid=1, ready=0, value=0.
  - `tail` advances by 1.
- CDB capture, per lane: if tag≠0 and entry[tag-1] is valid and not ready, store value and target_pc and set ready=1.
  - A tag of 0, or a tag pointing at an invalid or already-ready entry, is ignored.
  - Two lanes never carry the same tag.
- Retirement scan: lanes k = 0..`COMMIT_WIDTH`-1 examine entry (head+k) mod `DEPTH`. Lane k retires only if every lane below it retires and the entry is valid and ready. Additional per-lane rules:
  - ALU/load entry: retires. `commit_valid[k]`=1 and `commit_data[k]`=entry.
  - Store entry: retires only in lane 0 and only with `store_done`=1. It raises no `commit_valid`.
  - Branch entry with value=0: retires silently.
  - Branch entry with value=1 (taken): retires and stops the scan. Set `pcmux_sel`=1 and `target_pc`=entry target_pc. All other entries are cleared, `tail`=new `head`, and `count`=0. A simultaneous allocation is dropped.
- Retired entries are cleared. `head` advances by the retire count r.
- `count` next value = `count` + alloc − r, except after a taken-branch squash.
- `flush` or `rst`: all entries cleared, `head`=`tail`=0, `count`=0. Flush overrides allocation, CDB capture and retirement in that cycle.

## Timing
- Reset values: `commit_valid`=0, `commit_data`=0, `pcmux_sel`=0, `target_pc`=0, `count`=0, `empty`=1, `alloc_ready`=1, `alloc_tag`=1, `head_tag`=0, `head_is_store`=0.
- Minimum latency from an entry becoming ready to retirement is 1 cycle: a CDB capture at edge N allows retirement at edge N+1.
- `commit_valid`/`commit_data` and `pcmux_sel` are registered. They are visible in the cycle after the retiring edge and last one cycle.
- `alloc_ready`, `alloc_tag`, `head_tag` and `head_is_store` are combinational from registered state.
- When full, an allocation and a retirement in the same cycle are not both possible, because `alloc_ready`=0. The slot frees on the next cycle.
- Allocation, CDB capture and retirement of different entries may all happen on the same edge.
- An entry allocated at edge N can be captured by the CDB at edge N+1 at the earliest.

## Test plan
- Basic commit: reset, allocate 3 ALU ops (tags 1, 2, 3), CDB writes tags 3, 1, 2 with values 30, 10, 20 -> a single retirement cycle with `commit_valid`=2'b11 carrying 10 and 20, then the next cycle `commit_valid`=2'b01 carrying 30. `count` reaches 0.
- Full and wrap: allocate 8 entries -> `alloc_ready`=0 and `count`=8. Retire 2, allocate 2 -> `alloc_tag` wraps to 1, then 2. Values stay in order.
- Store handshake: store at head, ready, `store_done` held low for 3 cycles -> no retirement and `head_is_store`=1. Assert `store_done` -> store retires with `commit_valid`=0, and a following ready ALU op retires in lane 1 in the same cycle.
- Taken branch: ops A, BR(value 1, target 0x80), C, all ready -> A commits, `pcmux_sel`=1, `target_pc`=0x80, C discarded, `count`=0, `empty`=1.
- Flush mid-operation: 5 entries, flush together with alloc and a CDB hit -> next cycle `count`=0, no `commit_valid`, `alloc_tag`=1.
- CDB corner cases: tag 0, a tag for an unallocated entry, and a repeat of an already-captured tag -> no state change. The original value is kept.
